// File: rtl/mux_nto1_pipe.sv
// N-to-1 channel mux with a registered ready/valid output stage and a one-entry skid buffer.
// Optional illegal-select event counter (err_cnt_o) is enabled by defining MUX_NTO1_PIPE_ERRCNT_EN.
module mux_nto1_pipe #(
  parameter int SIZE  = 32,
  parameter int CH    = 3,
  parameter int SEL_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH*SIZE-1:0]   data_i,
  input  logic [SEL_W-1:0]     select_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [SIZE-1:0]      data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 illegal_o
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
  ,
  output logic [7:0]           err_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // One extra bit so the channel count itself is representable when CH == 2**SEL_W.
  localparam logic [SEL_W:0] CH_CODE = (SEL_W+1)'(CH);

  state_t          state_reg, state_next;
  logic [SIZE-1:0] data_reg, data_next;
  logic [SIZE-1:0] skid_reg, skid_next;
  logic            illegal_reg, illegal_next;
  logic [SIZE-1:0] chan [CH];
  logic [SIZE-1:0] sel_data;
  logic            sel_legal;
  logic            accept;
  logic            drain;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
      assign chan[gi] = data_i[gi*SIZE +: SIZE];
    end
  endgenerate

  // Codes at or above CH fall through to zero; they are never accepted anyway.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CH; k++) begin
      if (select_i == SEL_W'(k)) sel_data = chan[k];
    end
  end

  assign sel_legal = {1'b0, select_i} < CH_CODE;
  assign accept    = valid_i & ready_o & sel_legal;
  assign drain     = valid_o & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg   <= EMPTY;
      data_reg    <= '0;
      skid_reg    <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      skid_reg    <= skid_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    skid_next    = skid_reg;
    illegal_next = valid_i & ready_o & ~sel_legal;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          data_next  = sel_data;
        end
      end
      ONE: begin
        if (accept && drain) begin
          data_next = sel_data;
        end else if (accept) begin
          state_next = TWO;
          skid_next  = sel_data;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_next = ONE;
          data_next  = skid_reg;
          skid_next  = '0;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // ready_o deliberately has no path from ready_i, only from state and reset.
  always_comb begin
    ready_o   = rst_i && (state_reg != TWO);
    valid_o   = (state_reg != EMPTY);
    data_o    = data_reg;
    illegal_o = illegal_reg;
  end

`ifdef MUX_NTO1_PIPE_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_cnt_reg <= '0;
    end else if (illegal_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: directed scenarios plus randomized traffic against a queue model.
// Counter checks are compiled in when MUX_NTO1_PIPE_ERRCNT_EN is defined.
module tb_mux_nto1_pipe;

  localparam int SIZE  = 32;
  localparam int CH    = 3;
  localparam int SEL_W = 2;

  logic                clk_i;
  logic                rst_i;
  logic [CH*SIZE-1:0]  data_i;
  logic [SEL_W-1:0]    select_i;
  logic                valid_i;
  logic                ready_o;
  logic [SIZE-1:0]     data_o;
  logic                valid_o;
  logic                ready_i;
  logic                illegal_o;
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
  logic [7:0]          err_cnt_o;
`endif

  mux_nto1_pipe #(.SIZE(SIZE), .CH(CH), .SEL_W(SEL_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .select_i  (select_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .illegal_o (illegal_o)
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
    ,
    .err_cnt_o (err_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: a two-deep FIFO whose head is what data_o must show.
  logic [SIZE-1:0] q[$];
  bit              exp_illegal   = 0;
  int              exp_err       = 0;
  bit              data_zero_exp = 1;
  bit              model_on      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [SEL_W-1:0] sel, input bit rdy,
                      input bit rst, input logic [CH*SIZE-1:0] d);
    bit room;
    bit acc;
    bit drn;
    valid_i  = v;
    select_i = sel;
    ready_i  = rdy;
    rst_i    = rst;
    data_i   = d;
    @(posedge clk_i);
    if (!rst) begin
      q.delete();
      exp_illegal   = 0;
      exp_err       = 0;
      data_zero_exp = 1;
    end else begin
      room        = (q.size() < 2);
      acc         = v && room && (int'(sel) < CH);
      drn         = (q.size() > 0) && rdy;
      exp_illegal = v && room && (int'(sel) >= CH);
      if (exp_illegal && exp_err < 255) exp_err++;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(d[int'(sel)*SIZE +: SIZE]);
        data_zero_exp = 0;
      end
    end
    model_on = 1;
    @(negedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (model_on) begin
      chk("valid_o", valid_o, q.size() > 0);
      chk("ready_o", ready_o, rst_i && (q.size() < 2));
      chk("illegal_o", illegal_o, exp_illegal);
      if (q.size() > 0) chk("data_o", data_o, q[0]);
      else if (data_zero_exp) chk("data_o_cleared", data_o, 0);
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
      chk("err_cnt_o", err_cnt_o, exp_err);
`endif
    end
  end

  initial begin
    logic [CH*SIZE-1:0] d;
    logic [SEL_W-1:0]   sel;

    rst_i = 1'b0; valid_i = 1'b0; select_i = '0; ready_i = 1'b0; data_i = '0;
    d = {32'h33, 32'h22, 32'h11};

    repeat (3) step(0, 0, 1, 0, d);
    chk("reset_valid", valid_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_ready", ready_o, 0);
    chk("reset_illegal", illegal_o, 0);

    // Single word through channel 2.
    step(1, 2, 1, 1, d);
    chk("sel2_data", data_o, 32'h33);
    chk("sel2_valid", valid_o, 1);
    step(0, 0, 1, 1, d);
    chk("sel2_drained", valid_o, 0);

    // Back-pressure: fill output and skid, then drain in order.
    step(1, 0, 0, 1, {32'h0, 32'h0, 32'hA5A5_0001});
    step(1, 1, 0, 1, {32'h0, 32'hB5B5_0002, 32'h0});
    chk("full_ready", ready_o, 0);
    chk("full_head_a", data_o, 32'hA5A5_0001);
    step(1, 0, 0, 1, {32'h0, 32'h0, 32'hC5C5_0003});
    chk("full_hold_a", data_o, 32'hA5A5_0001);
    step(0, 0, 1, 1, d);
    chk("drain_b", data_o, 32'hB5B5_0002);
    chk("drain_b_valid", valid_o, 1);
    step(0, 0, 1, 1, d);
    chk("drain_empty", valid_o, 0);

    // Streaming one word per cycle.
    for (int i = 0; i < 9; i++) begin
      sel = SEL_W'(i % 3);
      d = {32'h300 + 32'(i), 32'h200 + 32'(i), 32'h100 + 32'(i)};
      step(1, sel, 1, 1, d);
      chk("stream_data", data_o, 32'h100 * (32'(i % 3) + 1) + 32'(i));
      chk("stream_ready", ready_o, 1);
    end
    step(0, 0, 1, 1, d);

    // Illegal select.
    d = {32'h33, 32'h22, 32'h11};
    step(1, 3, 1, 1, d);
    chk("illegal_pulse", illegal_o, 1);
    chk("illegal_no_valid", valid_o, 0);
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
    chk("err_cnt_one", err_cnt_o, 1);
`endif
    step(0, 3, 1, 1, d);
    chk("illegal_ignored_when_idle", illegal_o, 0);
    repeat (300) step(1, 3, 1, 1, d);
`ifdef MUX_NTO1_PIPE_ERRCNT_EN
    chk("err_cnt_sat", err_cnt_o, 255);
`endif
    step(0, 0, 1, 1, d);
    chk("illegal_clear", illegal_o, 0);

    // Reset while full.
    step(1, 0, 0, 1, d);
    step(1, 1, 0, 1, d);
    chk("pre_reset_full", ready_o, 0);
    step(0, 0, 0, 0, d);
    chk("mid_reset_valid", valid_o, 0);
    chk("mid_reset_ready", ready_o, 0);
    chk("mid_reset_data", data_o, 0);
    step(0, 0, 1, 1, d);
    chk("post_reset_ready", ready_o, 1);
    chk("post_reset_valid", valid_o, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      d = {$urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, SEL_W'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) != 0, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
